bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter.sv | 157 +++++++++++++++
 tb/tb_bram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester arbiter in front of one synchronous RAM port.
// Requester 0 is video and requester 1 is the CPU. Each accepted request
// drives the RAM port through registers. A read returns two cycles after
// acceptance, and its tag pipeline steers the result to the right requester.
// A burst counter caps consecutive grants to one owner while the other
// requester waits.
//
// Optional feature: define BRAM_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests round-robin instead of fixed priority (requester 0 first).
module bram_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wren,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_q
);

  localparam int CW = $clog2(BURST_MAX) + 1;
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win_any, win1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic          gnt0_q, gnt1_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_data_q;
  logic          mem_wren_q;
  // Read tag pipeline: [0] is set at acceptance, and [1] lines up with mem_q.
  logic [1:0]    rd_vld_q;
  logic [1:0]    rd_own_q;

  // Pick the winner. A lone requester always wins. A contested cycle goes to
  // the waiting side once the owner has used its whole burst.
  always_comb begin
    win_any = req0 | req1;
    win1    = 1'b0;
    if (req1 && !req0) begin
      win1 = 1'b1;
    end else if (req0 && req1) begin
      if (state_q == S_OWN0 && cnt_q == BMAX) begin
        win1 = 1'b1;
      end else if (state_q == S_OWN1 && cnt_q == BMAX) begin
        win1 = 1'b0;
      end else begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        // The requester not granted last wins; from IDLE requester 0 wins.
        win1 = (state_q == S_OWN0);
`else
        win1 = 1'b0;
`endif
      end
    end
  end

  // Mux the winning request onto the RAM-port fields.
  always_comb begin
    sel_we    = win1 ? we1    : we0;
    sel_addr  = win1 ? addr1  : addr0;
    sel_wdata = win1 ? wdata1 : wdata0;
  end

  // Owner state and saturating burst count. The count restarts at 1 whenever
  // ownership changes, including the first grant out of IDLE.
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = '0;
    if (win_any) begin
      state_d = win1 ? S_OWN1 : S_OWN0;
      if (state_d == state_q)
        cnt_d = (cnt_q == BMAX) ? cnt_q : cnt_q + ONE;
      else
        cnt_d = ONE;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered grant pulses and RAM-port drive. Address and data hold their
  // last value when idle. Write enable pulses once per accepted write.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      gnt0_q     <= win_any & ~win1;
      gnt1_q     <= win_any &  win1;
      mem_wren_q <= win_any & sel_we;
      if (win_any) begin
        mem_addr_q <= sel_addr;
        mem_data_q <= sel_wdata;
      end
    end
  end

  // Carry read ownership alongside the RAM latency. Reset drops in-flight
  // reads, so they never produce rvalid.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_vld_q <= '0;
      rd_own_q <= '0;
    end else begin
      rd_vld_q <= {rd_vld_q[0], win_any & ~sel_we};
      rd_own_q <= {rd_own_q[0], win1};
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign mem_addr = mem_addr_q;
  assign mem_wren = mem_wren_q;
  assign mem_data = mem_data_q;
  assign rvalid0  = rd_vld_q[1] & ~rd_own_q[1];
  assign rvalid1  = rd_vld_q[1] &  rd_own_q[1];
  // mem_q is valid in the cycle the tag reaches the last stage. Gating it keeps
  // rdata at 0 in reset and in cycles that return nothing.
  assign rdata    = rd_vld_q[1] ? mem_q : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a synchronous RAM model behind it.
// Define BRAM_ARB_ROUND_ROBIN_EN to check the round-robin grant order.
module tb_bram_arbiter;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic [9:0] mem_addr;
  logic       mem_wren;
  logic [7:0] mem_data;
  logic [7:0] mem_q;

  // RAM model with a preload port that is used only during reset.
  logic       pl_we;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;
  logic [7:0] ram [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  bram_arbiter #(.AW(10), .DW(8), .BURST_MAX(4)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_q(mem_q)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_reqs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_reqs();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    #2;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 0000", {gnt0, gnt1, rvalid0, rvalid1});
    end
    checks++;
    if ({mem_addr, mem_wren, mem_data, rdata} !== 27'b0) begin
      errors++; $display("FAIL reset_mem got addr=%h wren=%b data=%h rdata=%h want 0", mem_addr, mem_wren, mem_data, rdata);
    end
    // Preload the RAM while the arbiter is held in reset.
    pl_we = 1'b1; pl_addr = 10'h155; pl_data = 8'hA5; tick();
    pl_addr = 10'h001; pl_data = 8'h11; tick();
    pl_addr = 10'h002; pl_data = 8'h22; tick();
    pl_addr = 10'h003; pl_data = 8'h33; tick();
    pl_we = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1, mem_wren, rdata} !== 11'b0) begin
      errors++; $display("FAIL reset_held got gnt=%b%b wren=%b rdata=%h want 0", gnt0, gnt1, mem_wren, rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_read1();
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h155;
    tick();
    req1 = 1'b0;
    checks++;
    if ({gnt0, gnt1, mem_wren, mem_addr} !== {1'b0, 1'b1, 1'b0, 10'h155}) begin
      errors++; $display("FAIL read1_gnt got gnt0=%b gnt1=%b wren=%b addr=%h want 0 1 0 155", gnt0, gnt1, mem_wren, mem_addr);
    end
    tick();
    checks++;
    if ({rvalid0, rvalid1, rdata, gnt1} !== {1'b0, 1'b1, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL read1_rvalid got rv0=%b rv1=%b rdata=%h gnt1=%b want 0 1 a5 0", rvalid0, rvalid1, rdata, gnt1);
    end
    tick();
    checks++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      errors++; $display("FAIL read1_done got rv=%b%b want 00", rvalid0, rvalid1);
    end
  endtask

  task automatic test_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h010; wdata0 = 8'h3C;
    tick();
    idle_reqs();
    checks++;
    if ({gnt0, mem_wren, mem_addr, mem_data} !== {1'b1, 1'b1, 10'h010, 8'h3C}) begin
      errors++; $display("FAIL write_drive got gnt0=%b wren=%b addr=%h data=%h want 1 1 010 3c", gnt0, mem_wren, mem_addr, mem_data);
    end
    tick();
    checks++;
    if ({mem_wren, mem_addr, mem_data, rvalid0, rvalid1} !== {1'b0, 10'h010, 8'h3C, 2'b00}) begin
      errors++; $display("FAIL write_hold got wren=%b addr=%h data=%h rv=%b%b want 0 010 3c 00", mem_wren, mem_addr, mem_data, rvalid0, rvalid1);
    end
    tick();
    checks++;
    if ({rvalid0, rvalid1, mem_wren} !== 3'b000) begin
      errors++; $display("FAIL write_no_rvalid got rv=%b%b wren=%b want 000", rvalid0, rvalid1, mem_wren);
    end
    // Read the location back through the CPU port.
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h010;
    tick();
    req1 = 1'b0;
    tick();
    checks++;
    if ({rvalid1, rdata} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL write_readback got rv1=%b rdata=%h want 1 3c", rvalid1, rdata);
    end
    tick();
  endtask

  task automatic test_single();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h001;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
        errors++; $display("FAIL single0_c%0d got gnt0=%b gnt1=%b want 1 0", i, gnt0, gnt1);
      end
    end
    idle_reqs();
    tick(); tick(); tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h002;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
        errors++; $display("FAIL single1_c%0d got gnt0=%b gnt1=%b want 0 1", i, gnt0, gnt1);
      end
    end
    idle_reqs();
    tick(); tick(); tick();
  endtask

  task automatic test_burst();
    logic [11:0] seq;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    seq = 12'b1010_1010_1010;
`else
    seq = 12'b0010_0001_0000;
`endif
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h002;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({gnt1, gnt0} !== {seq[i], ~seq[i]}) begin
        errors++; $display("FAIL burst_gnt_c%0d got gnt0=%b gnt1=%b want gnt1=%b", i, gnt0, gnt1, seq[i]);
      end
      if (i > 0) begin
        checks++;
        if ({rvalid1, rvalid0, rdata} !== {seq[i-1], ~seq[i-1], (seq[i-1] ? 8'h22 : 8'h11)}) begin
          errors++; $display("FAIL burst_rd_c%0d got rv0=%b rv1=%b rdata=%h want rv1=%b", i, rvalid0, rvalid1, rdata, seq[i-1]);
        end
      end
    end
    idle_reqs();
    tick(); tick(); tick();
  endtask

  task automatic test_interleave();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h001;
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 10'h002;
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL il_gnt_a got gnt=%b%b want 10", gnt0, gnt1);
    end
    tick();
    req1 = 1'b0; req0 = 1'b1; addr0 = 10'h003;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, rdata} !== {4'b0110, 8'h11}) begin
      errors++; $display("FAIL il_b got gnt=%b%b rv=%b%b rdata=%h want 01 10 11", gnt0, gnt1, rvalid0, rvalid1, rdata);
    end
    tick();
    req0 = 1'b0;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, rdata} !== {4'b1001, 8'h22}) begin
      errors++; $display("FAIL il_c got gnt=%b%b rv=%b%b rdata=%h want 10 01 22", gnt0, gnt1, rvalid0, rvalid1, rdata);
    end
    tick();
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'h33}) begin
      errors++; $display("FAIL il_d got rv=%b%b rdata=%h want 10 33", rvalid0, rvalid1, rdata);
    end
    tick();
    checks++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      errors++; $display("FAIL il_e got rv=%b%b want 00", rvalid0, rvalid1);
    end
  endtask

  task automatic test_reset_inflight();
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h155;
    tick();
    req1 = 1'b0;
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++; $display("FAIL rst_if_gnt got gnt1=%b want 1", gnt1);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wren, mem_data} !== 31'b0) begin
      errors++; $display("FAIL rst_if_clear got gnt=%b%b rv=%b%b rdata=%h addr=%h wren=%b data=%h want 0",
                         gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wren, mem_data);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rvalid0, rvalid1, rdata, gnt0, gnt1} !== 12'b0) begin
        errors++; $display("FAIL rst_if_after_c%0d got rv=%b%b rdata=%h gnt=%b%b want 0", i, rvalid0, rvalid1, rdata, gnt0, gnt1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read1();
    test_write();
    test_single();
    test_burst();
    test_interleave();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
